// File: rtl/fm_pkg.sv
// Shared definitions for the FM stage sequencer: default widths, the gap
// length and the controller state encoding.
package fm_pkg;

    localparam int FM_BW      = 16;
    localparam int FM_AW      = 16;
    localparam int FM_GAP_CYC = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STD  = 3'd1,
        S_GAP  = 3'd2,
        S_MEAN = 3'd3,
        S_WAIT = 3'd4,
        S_FIN  = 3'd5
    } fm_state_e;

endpackage

// File: rtl/fm_stream_gen.sv
// Beat generator shared by the std and mean phases. It issues one buffer
// read per cycle for addresses 0..len-1, then produces the stage valid/last
// strobes one cycle later to cover the buffer read latency.
module fm_stream_gen
    import fm_pkg::*;
#(
    parameter int AW = FM_AW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          go_i,
    input  logic          sel_i,
    input  logic [AW-1:0] len_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          rd_sel_o,
    output logic          rd_final_o,
    output logic          std_valid_o,
    output logic          std_last_o,
    output logic          mean_valid_o,
    output logic          mean_last_o
);

    localparam logic [AW-1:0] ONE = AW'(1);

    logic          active_q, active_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          sel_q, sel_d;
    logic          vld_q;
    logic          lst_q;
    logic          vsel_q;
    logic          final_beat;

    // len_i is only consulted while active, by which time the caller has
    // latched it, so a go in the same cycle as the config latch is safe.
    assign final_beat = active_q && (addr_q == (len_i - ONE));

    // Next-state for the read window: restart on go, stop after len-1.
    always_comb begin
        active_d = active_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        if (go_i) begin
            active_d = 1'b1;
            addr_d   = '0;
            sel_d    = sel_i;
        end else if (active_q) begin
            if (final_beat) begin
                active_d = 1'b0;
                addr_d   = '0;
            end else begin
                addr_d = addr_q + ONE;
            end
        end
    end

    // Read-side registers plus the one-cycle delayed valid/last/select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            addr_q   <= '0;
            sel_q    <= 1'b0;
            vld_q    <= 1'b0;
            lst_q    <= 1'b0;
            vsel_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            vld_q    <= active_q;
            lst_q    <= final_beat;
            vsel_q   <= sel_q;
        end
    end

    assign rd_en_o      = active_q;
    assign rd_addr_o    = addr_q;
    assign rd_sel_o     = active_q & sel_q;
    assign rd_final_o   = final_beat;
    assign std_valid_o  = vld_q & ~vsel_q;
    assign std_last_o   = lst_q & ~vsel_q;
    assign mean_valid_o = vld_q & vsel_q;
    assign mean_last_o  = lst_q & vsel_q;

endmodule

// File: rtl/fm_stage_seq.sv
// Job sequencer for the FM stage: streams the std buffer, optionally waits
// a fixed gap and streams the mean buffer, then waits for the stage result
// with an optional timeout.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; config latched on start
// STD   | std buffer beats 0..len-1 being read
// GAP   | GAP_CYC idle cycles so the stage can settle the variance
// MEAN  | mean buffer beats 0..len-1 being read (mode 0 only)
// WAIT  | waiting for fm_out_valid && fm_out_last, timeout running
// FIN   | done pulse, back to IDLE
//
// GAP_CYC must be at least 1.
module fm_stage_seq
    import fm_pkg::*;
#(
    parameter int BW      = FM_BW,
    parameter int AW      = FM_AW,
    parameter int GAP_CYC = FM_GAP_CYC
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cfg_mode,
    input  logic [AW-1:0] cfg_len,
    input  logic [AW-1:0] cfg_timeout,
    output logic          buf_rd_en,
    output logic [AW-1:0] buf_rd_addr,
    output logic          buf_rd_sel,
    output logic          fm_mode,
    output logic          x_std_valid,
    output logic          x_std_last,
    output logic          x_mean_valid,
    output logic          x_mean_last,
    input  logic          fm_out_valid,
    input  logic          fm_out_last,
    input  logic [BW-1:0] fm_mean_var,
    input  logic [BW-1:0] fm_one_var,
    output logic [BW-1:0] res_mean_var,
    output logic [BW-1:0] res_one_var,
    output logic          busy,
    output logic          done,
    output logic          err_len,
    output logic          err_timeout
);

    localparam int            GW       = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    fm_state_e     state_q;
    logic          mode_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] tmo_q;
    logic [GW-1:0] gap_q;
    logic [AW-1:0] wcnt_q;
    logic [BW-1:0] res_mv_q;
    logic [BW-1:0] res_ov_q;
    logic          done_q;
    logic          err_len_q;
    logic          err_tmo_q;

    logic          go_std;
    logic          go_mean;
    logic          gen_final;
    logic          capture;
    logic          tmo_hit;

    // Beat generator is kicked on the same edge the FSM changes state so the
    // first read address appears in the first cycle of STD/MEAN.
    assign go_std  = (state_q == S_IDLE) && start && (cfg_len != '0);
    assign go_mean = (state_q == S_GAP) && (gap_q == '0);
    assign capture = fm_out_valid && fm_out_last;
    assign tmo_hit = (tmo_q != '0) && (wcnt_q == (tmo_q - ONE));

    fm_stream_gen #(
        .AW (AW)
    ) u_stream (
        .clk          (clk),
        .rst          (rst),
        .go_i         (go_std | go_mean),
        .sel_i        (go_mean),
        .len_i        (len_q),
        .rd_en_o      (buf_rd_en),
        .rd_addr_o    (buf_rd_addr),
        .rd_sel_o     (buf_rd_sel),
        .rd_final_o   (gen_final),
        .std_valid_o  (x_std_valid),
        .std_last_o   (x_std_last),
        .mean_valid_o (x_mean_valid),
        .mean_last_o  (x_mean_last)
    );

    // Sequencer FSM with config latch, gap/wait counters and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            len_q     <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            wcnt_q    <= '0;
            res_mv_q  <= '0;
            res_ov_q  <= '0;
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= cfg_mode;
                        len_q  <= cfg_len;
                        tmo_q  <= cfg_timeout;
                        if (cfg_len == '0) begin
                            err_len_q <= 1'b1;
                        end else begin
                            state_q <= S_STD;
                        end
                    end
                end
                S_STD: begin
                    if (gen_final) begin
                        if (mode_q) begin
                            state_q <= S_WAIT;
                            wcnt_q  <= '0;
                        end else begin
                            state_q <= S_GAP;
                            gap_q   <= GAP_LOAD;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= S_MEAN;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                S_MEAN: begin
                    if (gen_final) begin
                        state_q <= S_WAIT;
                        wcnt_q  <= '0;
                    end
                end
                S_WAIT: begin
                    // A result arriving on the timeout cycle still counts.
                    if (capture) begin
                        res_mv_q <= fm_mean_var;
                        res_ov_q <= fm_one_var;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end else if (tmo_hit) begin
                        err_tmo_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + ONE;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fm_mode      = mode_q;
    assign res_mean_var = res_mv_q;
    assign res_one_var  = res_ov_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign err_len      = err_len_q;
    assign err_timeout  = err_tmo_q;

endmodule

// File: tb/tb_fm_stage_seq.sv
// Bench for fm_stage_seq: each job's expected cycle-by-cycle outputs are
// derived from its start cycle, length, mode, timeout and result delay.
module tb_fm_stage_seq;

    localparam int BW = 16;
    localparam int AW = 16;
    localparam int G  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          cfg_mode = 1'b0;
    logic [AW-1:0] cfg_len = '0;
    logic [AW-1:0] cfg_timeout = '0;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic          buf_rd_sel;
    logic          fm_mode;
    logic          x_std_valid, x_std_last, x_mean_valid, x_mean_last;
    logic          fm_out_valid = 1'b0;
    logic          fm_out_last = 1'b0;
    logic [BW-1:0] fm_mean_var = '0;
    logic [BW-1:0] fm_one_var = '0;
    logic [BW-1:0] res_mean_var, res_one_var;
    logic          busy, done, err_len, err_timeout;

    int            checks = 0;
    int            failures = 0;
    logic [BW-1:0] exp_mv = '0;
    logic [BW-1:0] exp_ov = '0;
    logic          exp_mode = 1'b0;

    fm_stage_seq #(.BW(BW), .AW(AW), .GAP_CYC(G)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_mode     (cfg_mode),
        .cfg_len      (cfg_len),
        .cfg_timeout  (cfg_timeout),
        .buf_rd_en    (buf_rd_en),
        .buf_rd_addr  (buf_rd_addr),
        .buf_rd_sel   (buf_rd_sel),
        .fm_mode      (fm_mode),
        .x_std_valid  (x_std_valid),
        .x_std_last   (x_std_last),
        .x_mean_valid (x_mean_valid),
        .x_mean_last  (x_mean_last),
        .fm_out_valid (fm_out_valid),
        .fm_out_last  (fm_out_last),
        .fm_mean_var  (fm_mean_var),
        .fm_one_var   (fm_one_var),
        .res_mean_var (res_mean_var),
        .res_one_var  (res_one_var),
        .busy         (busy),
        .done         (done),
        .err_len      (err_len),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_cycle(input string ph, input int n, input bit rd, input bit sel, input int addr,
                             input bit sv, input bit sl, input bit mv, input bit ml,
                             input bit bz, input bit dn, input bit el, input bit et);
        chk($sformatf("%s@%0d.rd_en", ph, n), 32'(buf_rd_en), 32'(rd));
        if (rd) begin
            chk($sformatf("%s@%0d.rd_addr", ph, n), 32'(buf_rd_addr), 32'(addr));
            chk($sformatf("%s@%0d.rd_sel", ph, n), 32'(buf_rd_sel), 32'(sel));
        end
        chk($sformatf("%s@%0d.std_valid", ph, n), 32'(x_std_valid), 32'(sv));
        chk($sformatf("%s@%0d.std_last", ph, n), 32'(x_std_last), 32'(sl));
        chk($sformatf("%s@%0d.mean_valid", ph, n), 32'(x_mean_valid), 32'(mv));
        chk($sformatf("%s@%0d.mean_last", ph, n), 32'(x_mean_last), 32'(ml));
        chk($sformatf("%s@%0d.busy", ph, n), 32'(busy), 32'(bz));
        chk($sformatf("%s@%0d.done", ph, n), 32'(done), 32'(dn));
        chk($sformatf("%s@%0d.err_len", ph, n), 32'(err_len), 32'(el));
        chk($sformatf("%s@%0d.err_timeout", ph, n), 32'(err_timeout), 32'(et));
        chk($sformatf("%s@%0d.fm_mode", ph, n), 32'(fm_mode), 32'(exp_mode));
        chk($sformatf("%s@%0d.res_mean_var", ph, n), 32'(res_mean_var), 32'(exp_mv));
        chk($sformatf("%s@%0d.res_one_var", ph, n), 32'(res_one_var), 32'(exp_ov));
    endtask

    task automatic chk_quiet(input string ph, input int n);
        chk_cycle(ph, n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Cycle n counts edges after the start edge (n = 0 is the first cycle
    // after start is sampled). resp is the WAIT-relative cycle in which the
    // result is presented; -1 means never.
    task automatic run_job(input bit mode, input int len, input int tmo, input int resp,
                           input bit noise, input logic [BW-1:0] dmv, input logic [BW-1:0] dov);
        int  w, end_n, cap_n;
        bit  cap, rs, rm, in_wait;
        w     = mode ? len : 2 * len + G;
        cap   = (resp >= 0) && (tmo == 0 || resp < tmo);
        cap_n = w + resp + 1;
        end_n = cap ? w + resp + 2 : w + tmo;
        start = 1'b1; cfg_mode = mode; cfg_len = AW'(len); cfg_timeout = AW'(tmo);
        @(negedge clk);
        start = 1'b0;
        exp_mode = mode;
        for (int n = 0; n <= end_n; n++) begin
            rs = (n < len);
            rm = !mode && (n >= len + G) && (n < 2 * len + G);
            if (cap && n == cap_n) begin
                exp_mv = dmv;
                exp_ov = dov;
            end
            chk_cycle("job", n, rs | rm, rm, rs ? n : n - (len + G),
                      (n >= 1) && (n <= len), n == len,
                      !mode && (n >= len + G + 1) && (n <= 2 * len + G), !mode && (n == 2 * len + G),
                      n < end_n, cap && (n == cap_n), 1'b0, !cap && (n == w + tmo));
            in_wait = (n >= w) && (n < (cap ? cap_n : w + tmo));
            fm_mean_var = BW'($urandom);
            fm_one_var  = BW'($urandom);
            start = 1'b0;
            if (n == end_n) begin
                fm_out_valid = 1'b0;
                fm_out_last  = 1'b0;
            end else if (cap && n == w + resp) begin
                fm_out_valid = 1'b1;
                fm_out_last  = 1'b1;
                fm_mean_var  = dmv;
                fm_one_var   = dov;
            end else if (noise) begin
                fm_out_valid = 1'($urandom_range(0, 1));
                fm_out_last  = 1'($urandom_range(0, 1));
                if (in_wait && fm_out_valid && fm_out_last) fm_out_last = 1'b0;
                if ($urandom_range(0, 3) == 0 || (!mode && n == len + G + 1)) begin
                    start       = 1'b1;
                    cfg_mode    = 1'($urandom_range(0, 1));
                    cfg_len     = AW'($urandom_range(0, 9));
                    cfg_timeout = AW'($urandom_range(0, 9));
                end
            end else begin
                fm_out_valid = 1'b0;
                fm_out_last  = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_len0(input bit mode, input int tmo);
        start = 1'b1; cfg_mode = mode; cfg_len = '0; cfg_timeout = AW'(tmo);
        @(negedge clk);
        start = 1'b0;
        exp_mode = mode;
        chk_cycle("len0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk_quiet("len0", 1);
        @(negedge clk);
    endtask

    task automatic run_reset_mid();
        start = 1'b1; cfg_mode = 1'b0; cfg_len = AW'(4); cfg_timeout = '0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rstmid.pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        exp_mode = 1'b0; exp_mv = '0; exp_ov = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_quiet("rstmid", i);
        end
        rst = 1'b0;
        for (int i = 2; i < 5; i++) begin
            @(negedge clk);
            chk_quiet("rstmid", i);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_quiet("reset", 0);
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("reset", 1);

        run_job(1'b0, 4, 0, 5, 1'b0, 16'h3C00, 16'h4000);
        run_job(1'b1, 3, 0, 2, 1'b0, 16'h1234, 16'h5678);
        run_len0(1'b1, 7);
        run_job(1'b0, 2, 10, -1, 1'b0, 16'h0, 16'h0);
        run_job(1'b0, 4, 0, 3, 1'b1, 16'hA5A5, 16'h5A5A);
        run_reset_mid();
        run_job(1'b1, 2, 0, 0, 1'b0, 16'h7E01, 16'h0C3F);
        run_job(1'b1, 1, 10, 9, 1'b1, 16'hBEEF, 16'hCAFE);
        run_job(1'b1, 1, 1, 0, 1'b0, 16'h1111, 16'h2222);

        for (int j = 0; j < 12; j++) begin
            bit m;
            int l, t, r;
            m = 1'($urandom_range(0, 1));
            l = int'($urandom_range(1, 5));
            t = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(3, 12));
            r = (t == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, t + 2));
            if (t != 0 && r >= t) r = -1;
            run_job(m, l, t, r, 1'b1, BW'($urandom), BW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
